mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL provide a clk input, 1 bit, the single rising-edge clock for all state.
REQ-002 The block SHALL provide a rst input, 1 bit, synchronous active-high reset.
REQ-003 The block SHALL provide an Op input, 6 bits, instruction opcode taken from the instruction register.
REQ-004 The block SHALL provide a Func input, 6 bits, R-type function field.
REQ-005 The block SHALL provide a Zero input, 1 bit, ALU zero flag, valid in the EXE state.
REQ-006 The block SHALL provide a mem_ready input, 1 bit, completion handshake from the shared memory.
REQ-007 The block SHALL provide a PCWr output, 1 bit, PC write enable.
REQ-008 The block SHALL provide a PCSrc output, 2 bits, next-PC select: 0 = PC+4, 1 = branch target, 2 = jump immediate, 3 = rs register.
REQ-009 The block SHALL provide an IRWr output, 1 bit, instruction register load.
REQ-010 The block SHALL provide an RFWr output, 1 bit, register file write enable.
REQ-011 The block SHALL provide a MemRd output, 1 bit, memory read request.
REQ-012 The block SHALL provide a MemWr output, 1 bit, memory write request.
REQ-013 The block SHALL provide a state output, 3 bits, current FSM state.
REQ-014 The block SHALL provide an illegal output, 1 bit, one-cycle pulse when an unknown opcode is decoded.
REQ-015 The block SHALL provide an instr_cnt output, 32 bits, count of retired instructions.

Function
REQ-016 The FSM SHALL use the states FETCH=0, DECODE=1, EXE=2, MEM=3 and WB=4; codes 5-7 SHALL go to FETCH on the next clock.
REQ-017 FETCH SHALL behave as follows.
- MemRd=1 is held while mem_ready=0, and the FSM stays in FETCH.
- When mem_ready=1, the same cycle asserts IRWr=1, PCWr=1 and PCSrc=0, then goes to DECODE.
REQ-018 DECODE SHALL behave as follows.
- j (000010): PCWr=1, PCSrc=2, go to FETCH.
- jal (000011): PCWr=1, PCSrc=2, RFWr=1, go to FETCH.
- Legal opcodes 000000, 001000, 001010, 001101, 001111, 100011, 101011, 000100, 000101: go to EXE.
- Any other opcode: illegal=1, go to FETCH, with no write enables asserted.
REQ-019 EXE SHALL behave as follows.
- R-type other than jr/jalr, and the I-type ALU ops (001000, 001010, 001101, 001111): go to WB.
- lw/sw: go to MEM.
- beq: PCWr=Zero, PCSrc=1, go to FETCH.
- bne: PCWr=!Zero, PCSrc=1, go to FETCH.
- jr (Func 001000): PCWr=1, PCSrc=3, go to FETCH.
- jalr (Func 001001): PCWr=1, PCSrc=3, RFWr=1, go to FETCH.
REQ-020 MEM SHALL behave as follows.
- lw: MemRd=1, stay in MEM until mem_ready=1, then go to WB.
- sw: MemWr=1, stay in MEM until mem_ready=1, then go to FETCH.
REQ-021 WB SHALL assert RFWr=1 for exactly one cycle, then go to FETCH.
REQ-022 All outputs except state and instr_cnt SHALL be combinational from state, Op, Func, Zero and mem_ready; every enable not listed for a state SHALL be 0, and PCSrc SHALL default to 0.
REQ-023 Op and Func SHALL be sampled only in DECODE, EXE and MEM; changes on them in FETCH SHALL have no effect.
REQ-024 MemRd and MemWr SHALL never both be 1 in the same cycle.
REQ-025 mem_ready SHALL be ignored in DECODE, EXE and WB.
REQ-026 An instruction SHALL retire in the cycle the FSM enters FETCH from any state other than FETCH, except on an illegal decode.
REQ-027 Cycle counts with zero memory wait SHALL be: j/jal 2, beq/bne/jr/jalr 3, sw 4, ALU ops 4, lw 5.

Reset
REQ-028 While rst=1 at a clock edge, state SHALL be set to FETCH and instr_cnt to 0.
REQ-029 While rst=1, PCWr, IRWr, RFWr, MemRd, MemWr and illegal SHALL be forced to 0 and PCSrc to 0, regardless of state.
REQ-030 A reset asserted mid-instruction, including during a memory wait, SHALL abandon that instruction with no further write enables and without incrementing instr_cnt.

Configuration
REQ-031 With MC_PERF_CNT_EN defined, instr_cnt SHALL increment by 1 per retired instruction and wrap from 0xFFFFFFFF to 0.
REQ-032 Without MC_PERF_CNT_EN, instr_cnt SHALL be constant 0, and no counter register SHALL be synthesized.

Verification
REQ-033 The bench SHALL cover the following directed scenarios.
- add: reset, then fetch Op=000000, Func=100000 with mem_ready=1 every cycle -> states 0,1,2,4,0; RFWr=1 only in WB; instr_cnt=1 (macro on).
- lw with wait: Op=100011, mem_ready low for 2 MEM cycles -> MemRd=1 for 3 MEM cycles; then WB with RFWr=1; 7 cycles total with zero fetch wait.
- Branches: beq with Zero=0 -> PCWr=0 in EXE; bne with Zero=0 -> PCWr=1, PCSrc=1; both return to FETCH after 3 cycles.
- jal: Op=000011 -> in DECODE PCWr=1, PCSrc=2, RFWr=1; next state FETCH.
- Illegal: Op=111111 -> illegal pulses 1 cycle in DECODE; no enables asserted; instr_cnt unchanged.
- Reset mid-operation: rst=1 during a sw MEM wait -> MemWr=0 in that cycle; state=0 the next cycle; instr_cnt=0. With the macro off, instr_cnt=0 throughout.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXE/MEM/WB sequencing with a
// shared-memory ready handshake and a retired-instruction counter.
// Optional feature macro: MC_PERF_CNT_EN (enables the instr_cnt register;
// when undefined instr_cnt is tied to zero).
module mc_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  Op,
  input  logic [5:0]  Func,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWr,
  output logic [1:0]  PCSrc,
  output logic        IRWr,
  output logic        RFWr,
  output logic        MemRd,
  output logic        MemWr,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  state_t r_state;
  state_t w_next_state;

  logic w_is_jr;
  logic w_is_jalr;
  logic w_is_alu_i;
  logic w_illegal_dec;

  logic       w_pcwr;
  logic [1:0] w_pcsrc;
  logic       w_irwr;
  logic       w_rfwr;
  logic       w_memrd;
  logic       w_memwr;

  // Opcode/function classification shared by next-state and output logic
  always_comb begin
    w_is_jr    = (Op == OP_RTYPE) && (Func == FN_JR);
    w_is_jalr  = (Op == OP_RTYPE) && (Func == FN_JALR);
    w_is_alu_i = (Op == OP_ADDI) || (Op == OP_SLTI) ||
                 (Op == OP_ORI)  || (Op == OP_LUI);
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next_state;
  end

  // Next-state logic; unused encodings fall back to FETCH
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_RTYPE, OP_ADDI, OP_SLTI, OP_ORI, OP_LUI,
          OP_LW, OP_SW, OP_BEQ, OP_BNE: w_next_state = S_EXE;
          default:                      w_next_state = S_FETCH;
        endcase
      end
      S_EXE: begin
        if (Op == OP_RTYPE)
          w_next_state = (w_is_jr || w_is_jalr) ? S_FETCH : S_WB;
        else if (w_is_alu_i)
          w_next_state = S_WB;
        else if ((Op == OP_LW) || (Op == OP_SW))
          w_next_state = S_MEM;
        else
          w_next_state = S_FETCH;
      end
      S_MEM: begin
        if (Op == OP_LW)      w_next_state = mem_ready ? S_WB : S_MEM;
        else if (Op == OP_SW) w_next_state = mem_ready ? S_FETCH : S_MEM;
        else                  w_next_state = S_FETCH;
      end
      S_WB:    w_next_state = S_FETCH;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Per-state enables before reset gating
  always_comb begin
    w_pcwr        = 1'b0;
    w_pcsrc       = 2'd0;
    w_irwr        = 1'b0;
    w_rfwr        = 1'b0;
    w_memrd       = 1'b0;
    w_memwr       = 1'b0;
    w_illegal_dec = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memrd = 1'b1;
        if (mem_ready) begin
          w_irwr = 1'b1;
          w_pcwr = 1'b1;
        end
      end
      S_DECODE: begin
        case (Op)
          OP_J: begin
            w_pcwr  = 1'b1;
            w_pcsrc = 2'd2;
          end
          OP_JAL: begin
            w_pcwr  = 1'b1;
            w_pcsrc = 2'd2;
            w_rfwr  = 1'b1;
          end
          OP_RTYPE, OP_ADDI, OP_SLTI, OP_ORI, OP_LUI,
          OP_LW, OP_SW, OP_BEQ, OP_BNE: ;
          default: w_illegal_dec = 1'b1;
        endcase
      end
      S_EXE: begin
        if (Op == OP_BEQ) begin
          w_pcwr  = Zero;
          w_pcsrc = 2'd1;
        end else if (Op == OP_BNE) begin
          w_pcwr  = ~Zero;
          w_pcsrc = 2'd1;
        end else if (w_is_jr) begin
          w_pcwr  = 1'b1;
          w_pcsrc = 2'd3;
        end else if (w_is_jalr) begin
          w_pcwr  = 1'b1;
          w_pcsrc = 2'd3;
          w_rfwr  = 1'b1;
        end
      end
      S_MEM: begin
        if (Op == OP_LW)      w_memrd = 1'b1;
        else if (Op == OP_SW) w_memwr = 1'b1;
      end
      S_WB:    w_rfwr = 1'b1;
      default: ;
    endcase
  end

  // Reset masks every enable regardless of the state register contents
  always_comb begin
    PCWr    = w_pcwr        & ~rst;
    PCSrc   = rst ? 2'd0 : w_pcsrc;
    IRWr    = w_irwr        & ~rst;
    RFWr    = w_rfwr        & ~rst;
    MemRd   = w_memrd       & ~rst;
    MemWr   = w_memwr       & ~rst;
    illegal = w_illegal_dec & ~rst;
    state   = r_state;
  end

`ifdef MC_PERF_CNT_EN
  logic        w_retire;
  logic [31:0] r_instr_cnt;

  // Retirement is any return to FETCH from another state except an illegal decode
  always_comb begin
    w_retire = ~rst && (r_state != S_FETCH) && (w_next_state == S_FETCH) &&
               ~w_illegal_dec;
  end

  // Retired-instruction counter, wraps naturally at 32 bits
  always_ff @(posedge clk) begin
    if (rst)           r_instr_cnt <= '0;
    else if (w_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
  end

  assign instr_cnt = r_instr_cnt;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: builds the expected per-cycle output trace of each
// instruction from its class, then drives and compares cycle by cycle.
module tb_mc_control;

  logic        clk;
  logic        rst;
  logic [5:0]  Op;
  logic [5:0]  Func;
  logic        Zero;
  logic        mem_ready;
  logic        PCWr;
  logic [1:0]  PCSrc;
  logic        IRWr;
  logic        RFWr;
  logic        MemRd;
  logic        MemWr;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] instr_cnt;

  mc_control dut (
    .clk(clk), .rst(rst), .Op(Op), .Func(Func), .Zero(Zero),
    .mem_ready(mem_ready), .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr),
    .RFWr(RFWr), .MemRd(MemRd), .MemWr(MemWr), .state(state),
    .illegal(illegal), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwr;
    logic [1:0] src;
    logic       irwr;
    logic       rfwr;
    logic       memrd;
    logic       memwr;
    logic       ill;
    logic       rdy;
  } cyc_t;

  localparam int C_J = 0, C_JAL = 1, C_ALU = 2, C_LW = 3, C_SW = 4;
  localparam int C_BEQ = 5, C_BNE = 6, C_JR = 7, C_JALR = 8, C_ILL = 9;

  cyc_t        q[$];
  int unsigned nchecks;
  int unsigned nerr;
  int unsigned exp_cnt;

  function automatic cyc_t mk(input logic [2:0] st, input logic pcwr, input logic [1:0] src,
                              input logic irwr, input logic rfwr, input logic memrd,
                              input logic memwr, input logic ill, input logic rdy);
    cyc_t c;
    c.st = st; c.pcwr = pcwr; c.src = src; c.irwr = irwr; c.rfwr = rfwr;
    c.memrd = memrd; c.memwr = memwr; c.ill = ill; c.rdy = rdy;
    return c;
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'd0:  return (fn == 6'd8) ? C_JR : ((fn == 6'd9) ? C_JALR : C_ALU);
      6'd2:  return C_J;
      6'd3:  return C_JAL;
      6'd4:  return C_BEQ;
      6'd5:  return C_BNE;
      6'd8, 6'd10, 6'd13, 6'd15: return C_ALU;
      6'd35: return C_LW;
      6'd43: return C_SW;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected instruction trace: fetch waits, fetch, decode, then class-specific tail
  task automatic build(input int cls, input logic z, input int unsigned fw, input int unsigned mw);
    q.delete();
    for (int unsigned i = 0; i < fw; i++) q.push_back(mk(3'd0, 0, 2'd0, 0, 0, 1, 0, 0, 0));
    q.push_back(mk(3'd0, 1, 2'd0, 1, 0, 1, 0, 0, 1));
    case (cls)
      C_J:   q.push_back(mk(3'd1, 1, 2'd2, 0, 0, 0, 0, 0, rnd1()));
      C_JAL: q.push_back(mk(3'd1, 1, 2'd2, 0, 1, 0, 0, 0, rnd1()));
      C_ILL: q.push_back(mk(3'd1, 0, 2'd0, 0, 0, 0, 0, 1, rnd1()));
      default: q.push_back(mk(3'd1, 0, 2'd0, 0, 0, 0, 0, 0, rnd1()));
    endcase
    case (cls)
      C_BEQ:  q.push_back(mk(3'd2, z,  2'd1, 0, 0, 0, 0, 0, rnd1()));
      C_BNE:  q.push_back(mk(3'd2, !z, 2'd1, 0, 0, 0, 0, 0, rnd1()));
      C_JR:   q.push_back(mk(3'd2, 1,  2'd3, 0, 0, 0, 0, 0, rnd1()));
      C_JALR: q.push_back(mk(3'd2, 1,  2'd3, 0, 1, 0, 0, 0, rnd1()));
      C_ALU, C_LW, C_SW: q.push_back(mk(3'd2, 0, 2'd0, 0, 0, 0, 0, 0, rnd1()));
      default: ;
    endcase
    if (cls == C_LW || cls == C_SW) begin
      for (int unsigned i = 0; i <= mw; i++)
        q.push_back(mk(3'd3, 0, 2'd0, 0, 0, cls == C_LW, cls == C_SW, 0, i == mw));
    end
    if (cls == C_ALU || cls == C_LW) q.push_back(mk(3'd4, 0, 2'd0, 0, 1, 0, 0, 0, rnd1()));
  endtask

  function automatic logic [31:0] cnt_exp();
`ifdef MC_PERF_CNT_EN
    return exp_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_outs(input string tag, input cyc_t e);
    logic [9:0] obs, expv;
    obs  = {state, PCWr, PCSrc, IRWr, RFWr, MemRd, MemWr, illegal};
    expv = {e.st, e.pcwr, e.src, e.irwr, e.rfwr, e.memrd, e.memwr, e.ill};
    nchecks++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s outs {st,pcwr,src,irwr,rfwr,rd,wr,ill}: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_cnt(input string tag);
    nchecks++;
    assert (instr_cnt === cnt_exp()) else begin
      nerr++;
      $error("FAIL %s instr_cnt: observed %0d expected %0d", tag, instr_cnt, cnt_exp());
    end
  endtask

  // Drive one instruction; Op/Func are scrambled during FETCH since they must be ignored there.
  // With stop_at_mem set, returns just before the first MEM cycle.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int unsigned fw, input int unsigned mw,
                           input bit stop_at_mem);
    int cls;
    cls = classify(op, fn);
    build(cls, z, fw, mw);
    foreach (q[i]) begin
      if (stop_at_mem && q[i].st == 3'd3) return;
      if (q[i].st == 3'd0) begin
        Op   = 6'($urandom);
        Func = 6'($urandom);
      end else begin
        Op   = op;
        Func = fn;
      end
      Zero      = z;
      mem_ready = q[i].rdy;
      #1;
      check_outs(tag, q[i]);
      check_cnt(tag);
      @(posedge clk); #1;
    end
    if (cls != C_ILL) exp_cnt++;
  endtask

  logic [5:0] op_tab[14];
  logic [5:0] fn_tab[4];

  initial begin
    nchecks = 0; nerr = 0; exp_cnt = 0;
    rst = 1'b1; Op = '0; Func = '0; Zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Reset state with mem_ready high: FETCH enables must stay masked
    check_outs("reset", mk(3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    check_cnt("reset");
    rst = 1'b0;

    run_instr("add",  6'd0,  6'h20, 1'b0, 0, 0, 1'b0);
    check_cnt("add_retired");
    run_instr("lw_wait", 6'd35, 6'd0, 1'b0, 0, 2, 1'b0);
    run_instr("beq_z0",  6'd4,  6'd0, 1'b0, 0, 0, 1'b0);
    run_instr("bne_z0",  6'd5,  6'd0, 1'b0, 0, 0, 1'b0);
    run_instr("beq_z1",  6'd4,  6'd0, 1'b1, 1, 0, 1'b0);
    run_instr("jal",     6'd3,  6'd0, 1'b0, 0, 0, 1'b0);
    run_instr("illegal", 6'h3f, 6'd0, 1'b0, 0, 0, 1'b0);
    run_instr("jr",      6'd0,  6'd8, 1'b0, 0, 0, 1'b0);
    run_instr("jalr",    6'd0,  6'd9, 1'b0, 0, 0, 1'b0);
    run_instr("sw_wait", 6'd43, 6'd0, 1'b0, 2, 1, 1'b0);
    check_cnt("directed_done");

    op_tab = '{6'd0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd10,
               6'd13, 6'd15, 6'd35, 6'd43, 6'd0, 6'd1};
    fn_tab = '{6'h20, 6'd8, 6'd9, 6'h2a};
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op, fn;
      op = op_tab[$urandom_range(0, 13)];
      if (n % 10 == 9) op = 6'($urandom);
      fn = fn_tab[$urandom_range(0, 3)];
      run_instr("random", op, fn, rnd1(), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    end
    check_cnt("random_done");

    // Reset during a store's memory wait
    run_instr("sw_rst", 6'd43, 6'd0, 1'b0, 0, 3, 1'b1);
    Op = 6'd43; mem_ready = 1'b0; #1;
    check_outs("sw_mem_pre", mk(3'd3, 0, 2'd0, 0, 0, 0, 1, 0, 0));
    rst = 1'b1; #1;
    check_outs("sw_mem_rst", mk(3'd3, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    check_cnt("sw_mem_rst");
    @(posedge clk); #1;
    exp_cnt = 0;
    mem_ready = 1'b1; #1;
    check_outs("after_rst", mk(3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    check_cnt("after_rst");
    rst = 1'b0;
    run_instr("add_post", 6'd0, 6'h20, 1'b0, 0, 0, 1'b0);
    #1;
    check_cnt("final");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
